// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-bank writeback arbiter.
package regfile_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;

    // Register 0 is hardwired; writes to it are acknowledged but never committed.
    localparam int ZERO_REG = 0;

    // wb_src encoding
    localparam logic SRC_PIPE = 1'b0;
    localparam logic SRC_MDU  = 1'b1;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_PIPE,
        SEL_MDU
    } sel_e;

endpackage

// File: rtl/regfile_wb_arbiter_starve_counter.sv
// Saturating count of consecutive cycles the mult/div writeback has waited;
// at_max tells the arbiter to force it through.
module starve_counter #(
    parameter int MAX = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic at_max
);

    localparam int W = $clog2(MAX + 1);

    logic [W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_max = (cnt == W'(MAX));

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single regfile write port between the pipeline writeback (A)
// and the mult/div unit (B), with starvation forcing for B and r0 suppression.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W     = RF_DATA_W,
    parameter int ADDR_W     = RF_ADDR_W,
    parameter int STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              b_squash,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] wRegAddrs,
    output logic [DATA_W-1:0] wData,
    output logic              wb_src
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic at_max;
    logic force_b;
    logic collide;
    logic a_xfer;
    logic b_xfer;
    sel_e sel;

    starve_counter #(
        .MAX(STARVE_MAX)
    ) u_starve (
        .clock (clock),
        .reset (reset),
        .clear (!b_valid || b_ready),
        .inc   (b_valid && !b_ready),
        .at_max(at_max)
    );

    // A forced B wins even on an address match; A then retries and lands last.
    assign force_b = b_valid && at_max;
    assign collide = a_valid && b_valid && (a_addr == b_addr)
                     && (a_addr != ZERO_ADDR) && !force_b;

    assign a_ready  = !force_b;
    assign b_ready  = !a_valid || force_b || collide;
    assign b_squash = collide;

    assign a_xfer = a_valid && a_ready;
    assign b_xfer = b_valid && b_ready && !collide;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    always_comb begin
        sel = SEL_NONE;
        if (a_xfer) begin
            sel = SEL_PIPE;
        end else if (b_xfer) begin
            sel = SEL_MDU;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            RegWrite  <= 1'b0;
            wRegAddrs <= '0;
            wData     <= '0;
            wb_src    <= SRC_PIPE;
        end else begin
            case (sel)
                SEL_PIPE: begin
                    RegWrite  <= (a_addr != ZERO_ADDR);
                    wRegAddrs <= a_addr;
                    wData     <= a_data;
                    wb_src    <= SRC_PIPE;
                end
                SEL_MDU: begin
                    RegWrite  <= (b_addr != ZERO_ADDR);
                    wRegAddrs <= b_addr;
                    wData     <= b_data;
                    wb_src    <= SRC_MDU;
                end
                default: begin
                    RegWrite <= 1'b0;
                    wb_src   <= SRC_PIPE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: single-cycle vector table plus
// hand sequences for reset, starvation forcing and forced same-address writes.
module tb_regfile_wb_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        a_valid, b_valid;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready, b_squash;
    logic        RegWrite, wb_src;
    logic [4:0]  wRegAddrs;
    logic [31:0] wData;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    regfile_wb_arbiter #(
        .DATA_W(32),
        .ADDR_W(5),
        .STARVE_MAX(4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .a_valid  (a_valid),
        .a_addr   (a_addr),
        .a_data   (a_data),
        .a_ready  (a_ready),
        .b_valid  (b_valid),
        .b_addr   (b_addr),
        .b_data   (b_data),
        .b_ready  (b_ready),
        .b_squash (b_squash),
        .RegWrite (RegWrite),
        .wRegAddrs(wRegAddrs),
        .wData    (wData),
        .wb_src   (wb_src)
    );

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  ba;
        logic [31:0] bd;
        logic        ar;
        logic        br;
        logic        sq;
        logic        rw;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        src;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic bv, input logic [4:0] ba, input logic [31:0] bd);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
    endtask

    task automatic check_comb(input string tag, input logic ar, input logic br, input logic sq);
        check({tag, " a_ready"}, a_ready, ar);
        check({tag, " b_ready"}, b_ready, br);
        check({tag, " b_squash"}, b_squash, sq);
    endtask

    task automatic check_regs(input string tag, input logic rw, input logic [4:0] wa,
                              input logic [31:0] wd, input logic src);
        check({tag, " RegWrite"}, RegWrite, rw);
        check({tag, " wRegAddrs"}, wRegAddrs, wa);
        check({tag, " wData"}, wData, wd);
        check({tag, " wb_src"}, wb_src, src);
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled 3 units later
    // (combinational) and 1 unit after the next edge (registered).
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        //           av aa  ad            bv ba  bd            ar br sq  rw wa  wd            src
        vecs[0] = '{1, 8,  32'h0000_00FF, 0, 0,  32'h0,        1, 0, 0,  1, 8,  32'h0000_00FF, 0};
        vecs[1] = '{1, 0,  32'hDEAD_BEEF, 0, 0,  32'h0,        1, 0, 0,  0, 0,  32'hDEAD_BEEF, 0};
        vecs[2] = '{0, 0,  32'h0,        1, 12, 32'h0000_CAFE, 1, 1, 0,  1, 12, 32'h0000_CAFE, 1};
        vecs[3] = '{0, 0,  32'h0,        1, 0,  32'h0000_0077, 1, 1, 0,  0, 0,  32'h0000_0077, 1};
        vecs[4] = '{0, 0,  32'h0,        0, 0,  32'h0,        1, 1, 0,  0, 0,  32'h0000_0077, 0};
        vecs[5] = '{1, 5,  32'h0000_0011, 1, 5,  32'h0000_0022, 1, 1, 1,  1, 5,  32'h0000_0011, 0};
        vecs[6] = '{1, 0,  32'h0000_0033, 1, 0,  32'h0000_0044, 1, 0, 0,  0, 0,  32'h0000_0033, 0};
        vecs[7] = '{0, 0,  32'h0,        0, 0,  32'h0,        1, 1, 0,  0, 0,  32'h0000_0033, 0};
        vecs[8] = '{1, 3,  32'h0000_AAAA, 0, 0,  32'h0,        1, 0, 0,  1, 3,  32'h0000_AAAA, 0};
        vecs[9] = '{0, 0,  32'h0,        1, 31, 32'hFFFF_FFFF, 1, 1, 0,  1, 31, 32'hFFFF_FFFF, 1};

        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        #2;
        check_regs("reset", 0, 0, 0, 0);
        check_comb("reset idle", 1, 1, 0);
        #10;
        reset = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].bv, vecs[i].ba, vecs[i].bd);
            #3;
            check_comb($sformatf("vec%0d", i), vecs[i].ar, vecs[i].br, vecs[i].sq);
            tick();
            check_regs($sformatf("vec%0d", i), vecs[i].rw, vecs[i].wa, vecs[i].wd, vecs[i].src);
        end

        // Starvation: B waits four cycles behind a steady A, then is forced.
        drive(1, 9, 32'h0000_0099, 1, 10, 32'h0000_1234);
        for (int k = 0; k < 4; k++) begin
            #3;
            check_comb($sformatf("starve wait%0d", k), 1, 0, 0);
            tick();
            check_regs($sformatf("starve wait%0d", k), 1, 9, 32'h0000_0099, 0);
        end
        #3;
        check_comb("starve force", 0, 1, 0);
        tick();
        check_regs("starve force", 1, 10, 32'h0000_1234, 1);
        #3;
        check_comb("starve cleared", 1, 0, 0);
        tick();
        check_regs("starve cleared", 1, 9, 32'h0000_0099, 0);

        // Forced B to the same register as a pending A: B lands first, A second.
        drive(0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 6, 32'h0000_0066, 1, 5, 32'h0000_0022);
        repeat (4) tick();
        drive(1, 5, 32'h0000_0011, 1, 5, 32'h0000_0022);
        #3;
        check_comb("forced same", 0, 1, 0);
        tick();
        check_regs("forced same N", 1, 5, 32'h0000_0022, 1);
        drive(1, 5, 32'h0000_0011, 0, 0, 0);
        #3;
        check_comb("forced retry", 1, 0, 0);
        tick();
        check_regs("forced same N+1", 1, 5, 32'h0000_0011, 0);

        // Reset while a write is in flight clears the registered outputs at once.
        drive(0, 0, 0, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        check_regs("async reset", 0, 0, 0, 0);
        #1;
        reset = 1'b0;
        drive(1, 7, 32'h0000_0707, 1, 8, 32'h0000_0808);
        #1;
        check_comb("post reset", 1, 0, 0);
        tick();
        check_regs("post reset", 1, 7, 32'h0000_0707, 0);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        check_regs("post reset idle", 0, 7, 32'h0000_0707, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
